// File: rtl/anatool_scan_sequencer_if.sv
// Register-port bundle between the TinyQV peripheral bus and the scan sequencer.
// master: CPU side (drives address/strobe/data); slave: sequencer side (returns read data).
interface anatool_scan_sequencer_if;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;

   modport master (
      output address,
      output data_write,
      output data_in,
      input  data_out
   );

   modport slave (
      input  address,
      input  data_write,
      input  data_in,
      output data_out
   );
endinterface

// File: rtl/anatool_scan_sequencer.sv
// Round-robin channel scanner for the duty-measurement datapath.
// Steps ch_sel across the set bits of MASK and pulses meas_restart on every switch.
// It drops DISCARD_WIN windows after each switch, then stores that channel's duty byte.
// Optional feature macro: ANATOOL_SCAN_AVG2_EN, which averages two windows per capture.
module anatool_scan_sequencer #(
   parameter int unsigned NUM_CH      = 8,
   parameter int unsigned DISCARD_WIN = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   anatool_scan_sequencer_if.slave         bus,
   input  logic                            win_done,
   input  logic [7:0]                      duty_value,
   output logic [2:0]                      ch_sel,
   output logic                            meas_restart
);

   typedef enum logic [1:0] {StIdle, StSelect, StSettle, StCapture} state_e;

`ifdef ANATOOL_SCAN_AVG2_EN
   localparam logic AvgBit = 1'b1;
`else
   localparam logic AvgBit = 1'b0;
`endif

   state_e            state_q;
   logic [7:0]        mask_q;
   logic              cont_q;
   logic              busy_q;
   logic              done_q;
   logic [1:0]        disc_cnt_q;
   logic [NUM_CH-1:0] valid_q;
   logic [7:0]        result_q [NUM_CH];

   logic [NUM_CH-1:0] eff_mask;
   logic [2:0]        lowest_ch;
   logic [2:0]        above_ch;
   logic              have_above;
   logic              ctrl_wr;
   logic              start;
   logic              stop;
   logic              mask_wr;
   logic              done_clr;
   logic              capture_fire;
   logic [7:0]        capture_value;

`ifdef ANATOOL_SCAN_AVG2_EN
   logic [7:0]        first_q;
   logic              have_first_q;
   logic [8:0]        sum9;
`endif

   // Bits at or above NUM_CH never select a channel.
   assign eff_mask = mask_q[NUM_CH-1:0];

   assign ctrl_wr  = bus.data_write && (bus.address == 4'd0);
   assign start    = ctrl_wr && bus.data_in[0];
   assign stop     = ctrl_wr && bus.data_in[2];
   assign mask_wr  = bus.data_write && (bus.address == 4'd1);
   assign done_clr = bus.data_write && (bus.address == 4'd2) && bus.data_in[6];

   // Lowest set mask bit overall, and lowest set mask bit strictly above ch_sel.
   always_comb begin
      lowest_ch  = 3'd0;
      above_ch   = 3'd0;
      have_above = 1'b0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (eff_mask[i]) begin
            lowest_ch = 3'(i);
            if (i > int'(ch_sel)) begin
               above_ch   = 3'(i);
               have_above = 1'b1;
            end
         end
      end
   end

   // Decide whether this win_done completes a capture and what value it stores.
`ifdef ANATOOL_SCAN_AVG2_EN
   always_comb begin
      sum9          = {1'b0, first_q} + {1'b0, duty_value} + 9'd1;
      capture_fire  = win_done && have_first_q;
      capture_value = sum9[8:1];
   end
`else
   always_comb begin
      capture_fire  = win_done;
      capture_value = duty_value;
   end
`endif

   // Register read mux; unmapped addresses return zero.
   always_comb begin
      bus.data_out = 8'h00;
      case (bus.address)
         4'd1: bus.data_out = mask_q;
         4'd2: bus.data_out = {busy_q, done_q, cont_q, 1'b0, AvgBit, ch_sel};
         4'd3: bus.data_out = 8'(valid_q);
         default: begin
            if (bus.address[3] && (32'(bus.address[2:0]) < NUM_CH)) begin
               bus.data_out = result_q[bus.address[2:0]];
            end
         end
      endcase
   end

   // Scan FSM with registered outputs, result bank and register writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ch_sel       <= 3'd0;
         meas_restart <= 1'b0;
         mask_q       <= 8'h00;
         cont_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         disc_cnt_q   <= 2'd0;
         valid_q      <= '0;
         for (int i = 0; i < int'(NUM_CH); i++) begin
            result_q[i] <= 8'h00;
         end
`ifdef ANATOOL_SCAN_AVG2_EN
         first_q      <= 8'h00;
         have_first_q <= 1'b0;
`endif
      end else begin
         if (mask_wr) begin
            mask_q <= bus.data_in;
         end
         if (done_clr) begin
            done_q <= 1'b0;
         end
         // Stop outranks everything, including a same-cycle win_done.
         if (stop) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            meas_restart <= 1'b0;
`ifdef ANATOOL_SCAN_AVG2_EN
            have_first_q <= 1'b0;
`endif
         end else begin
            case (state_q)
               StIdle: begin
                  if (start && (eff_mask != '0)) begin
                     cont_q       <= bus.data_in[1];
                     valid_q      <= '0;
                     done_q       <= 1'b0;
                     busy_q       <= 1'b1;
                     ch_sel       <= lowest_ch;
                     meas_restart <= 1'b1;
                     state_q      <= StSelect;
                  end
               end
               StSelect: begin
                  meas_restart <= 1'b0;
                  disc_cnt_q   <= 2'(DISCARD_WIN);
`ifdef ANATOOL_SCAN_AVG2_EN
                  have_first_q <= 1'b0;
`endif
                  if (DISCARD_WIN > 0) begin
                     state_q <= StSettle;
                  end else begin
                     state_q <= StCapture;
                  end
               end
               StSettle: begin
                  if (win_done) begin
                     disc_cnt_q <= disc_cnt_q - 2'd1;
                     if (disc_cnt_q == 2'd1) begin
                        state_q <= StCapture;
                     end
                  end
               end
               StCapture: begin
`ifdef ANATOOL_SCAN_AVG2_EN
                  if (win_done && !have_first_q) begin
                     first_q      <= duty_value;
                     have_first_q <= 1'b1;
                  end
`endif
                  if (capture_fire) begin
                     result_q[ch_sel] <= capture_value;
                     valid_q[ch_sel]  <= 1'b1;
                     // Mask is sampled here, so a mid-scan MASK write lands at this advance.
                     if ((eff_mask == '0) || (!have_above && !cont_q)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                     end else begin
                        ch_sel       <= have_above ? above_ch : lowest_ch;
                        meas_restart <= 1'b1;
                        state_q      <= StSelect;
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
